// File: rtl/arb_req_queue_if.sv
// Handshake bundle for arb_req_queue: two producer streams, arbiter req/grant, output stream.
interface arb_req_queue_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              in1_valid;
  logic [DATA_W-1:0] in1_data;
  logic              in1_ready;
  logic              in2_valid;
  logic [DATA_W-1:0] in2_data;
  logic              in2_ready;
  logic              req_1;
  logic              req_2;
  logic              grant_1;
  logic              grant_2;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_src;

  // Environment side: producers, arbiter and consumer.
  modport master (
    output in1_valid, in1_data, in2_valid, in2_data, grant_1, grant_2,
    input  in1_ready, in2_ready, req_1, req_2, out_valid, out_data, out_src
  );

  // Queue side.
  modport slave (
    input  in1_valid, in1_data, in2_valid, in2_data, grant_1, grant_2,
    output in1_ready, in2_ready, req_1, req_2, out_valid, out_data, out_src
  );
endinterface

// File: rtl/arb_req_queue.sv
// Two per-source FIFOs feeding a two-port arbiter; granted entries leave on one registered stream.
// Optional ARB_REQ_QUEUE_STATS_EN builds the saturating spurious-grant counter spur_cnt.
module arb_req_queue #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  arb_req_queue_if.slave      bus
`ifdef ARB_REQ_QUEUE_STATS_EN
  ,
  output logic [15:0]         spur_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q  [2][DEPTH];
  logic [PW-1:0]     wptr_q [2];
  logic [PW-1:0]     rptr_q [2];
  logic [CW-1:0]     cnt_q  [2];
  logic [CW-1:0]     cnt_d  [2];
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        in_valid, in_ready, push, grant, acc, req;
  logic [DATA_W-1:0] pop_data;
  logic              out_valid_q, out_src_q;
  logic [DATA_W-1:0] out_data_q;

  assign in_valid   = {bus.in2_valid, bus.in1_valid};
  assign in_data[0] = bus.in1_data;
  assign in_data[1] = bus.in2_data;
  assign grant      = {bus.grant_2, bus.grant_1};

  always_comb begin
    in_ready = '0;
    push     = '0;
    req      = '0;
    for (int i = 0; i < 2; i++) begin
      // Ready depends on occupancy only: a full FIFO refuses even while popping.
      in_ready[i] = (cnt_q[i] != FULL);
      push[i]     = in_valid[i] & in_ready[i];
    end
    // grant_1 wins if the arbiter ever raises both.
    acc[0] = grant[0] & (cnt_q[0] != '0);
    acc[1] = grant[1] & ~grant[0] & (cnt_q[1] != '0);
    for (int i = 0; i < 2; i++) begin
      // Drop the request when the only remaining entry is being popped now.
      req[i]   = (cnt_q[i] > CW'(acc[i]));
      cnt_d[i] = cnt_q[i];
      if (push[i] && !acc[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (!push[i] && acc[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
    pop_data = acc[0] ? mem_q[0][rptr_q[0]] : mem_q[1][rptr_q[1]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + PW'(1);
        if (acc[i])  rptr_q[i] <= rptr_q[i] + PW'(1);
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= in_data[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      out_valid_q <= |acc;
      if (|acc) begin
        out_data_q <= pop_data;
        out_src_q  <= acc[1];
      end
    end
  end

`ifdef ARB_REQ_QUEUE_STATS_EN
  logic        spurious;
  logic [15:0] spur_q;

  assign spurious = (grant[0] & ~acc[0]) | (grant[1] & ~acc[1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spur_q <= '0;
    end else if (spurious && (spur_q != 16'hFFFF)) begin
      spur_q <= spur_q + 16'd1;
    end
  end

  assign spur_cnt = spur_q;
`endif

  assign bus.in1_ready = in_ready[0];
  assign bus.in2_ready = in_ready[1];
  assign bus.req_1     = req[0];
  assign bus.req_2     = req[1];
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench for arb_req_queue: vector table plus reset, spurious-grant and mid-drain sequences.
module tb_arb_req_queue;

  logic clk;
  logic reset_n;
`ifdef ARB_REQ_QUEUE_STATS_EN
  logic [15:0] spur_cnt;
`endif

  arb_req_queue_if #(.DATA_W(8)) bus ();

  arb_req_queue #(
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus)
`ifdef ARB_REQ_QUEUE_STATS_EN
    ,
    .spur_cnt (spur_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v1;
    logic [7:0] d1;
    logic       v2;
    logic [7:0] d2;
    logic       g1;
    logic       g2;
    logic       rdy1;
    logic       rdy2;
    logic       rq1;
    logic       rq2;
    logic       ov;
    logic [7:0] od;
    logic       os;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v1, input logic [7:0] d1, input logic v2,
                              input logic [7:0] d2, input logic g1, input logic g2,
                              input logic rdy1, input logic rdy2, input logic rq1,
                              input logic rq2, input logic ov, input logic [7:0] od,
                              input logic os);
    vec_t v;
    v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2; v.g1 = g1; v.g2 = g2;
    v.rdy1 = rdy1; v.rdy2 = rdy2; v.rq1 = rq1; v.rq2 = rq2;
    v.ov = ov; v.od = od; v.os = os;
    return v;
  endfunction

  task automatic drive(input logic v1, input logic [7:0] d1, input logic v2,
                       input logic [7:0] d2, input logic g1, input logic g2);
    bus.in1_valid = v1;
    bus.in1_data  = d1;
    bus.in2_valid = v2;
    bus.in2_data  = d2;
    bus.grant_1   = g1;
    bus.grant_2   = g2;
  endtask

  initial begin
    // Inputs sampled at posedge; outputs checked at the following negedge.
    //           v1 d1     v2 d2     g1 g2  rdy1 rdy2 rq1 rq2 ov od     os
    // single source
    tbl.push_back(mk(1, 8'hA1, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 8'hA2, 0, 8'h00, 0, 0, 1, 1, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 1, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 1, 0, 0, 1, 8'hA1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 8'hA2, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 8'hA2, 0));
    // contention, alternating grants
    tbl.push_back(mk(1, 8'h10, 1, 8'h20, 0, 0, 1, 1, 0, 0, 0, 8'hA2, 0));
    tbl.push_back(mk(1, 8'h11, 1, 8'h21, 0, 0, 1, 1, 1, 1, 0, 8'hA2, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 1, 1, 1, 0, 8'hA2, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 1, 1, 1, 1, 1, 8'h10, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 1, 0, 1, 1, 8'h20, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 1, 1, 0, 0, 1, 8'h11, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 8'h21, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 8'h21, 1));
    // fill source 2, refused 5th push, drain across pointer wrap
    tbl.push_back(mk(0, 8'h00, 1, 8'h30, 0, 0, 1, 1, 0, 0, 0, 8'h21, 1));
    tbl.push_back(mk(0, 8'h00, 1, 8'h31, 0, 0, 1, 1, 0, 1, 0, 8'h21, 1));
    tbl.push_back(mk(0, 8'h00, 1, 8'h32, 0, 0, 1, 1, 0, 1, 0, 8'h21, 1));
    tbl.push_back(mk(0, 8'h00, 1, 8'h33, 0, 0, 1, 1, 0, 1, 0, 8'h21, 1));
    tbl.push_back(mk(0, 8'h00, 1, 8'h34, 0, 0, 1, 0, 0, 1, 0, 8'h21, 1));
    tbl.push_back(mk(0, 8'h00, 1, 8'h34, 0, 1, 1, 0, 0, 1, 0, 8'h21, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 1, 1, 0, 1, 1, 8'h30, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 1, 1, 0, 1, 1, 8'h31, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 1, 1, 0, 0, 1, 8'h32, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 1, 1, 0, 0, 1, 8'h33, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 8'h33, 1));
    // push into empty while granted: not poppable until next cycle
    tbl.push_back(mk(1, 8'h40, 0, 8'h00, 1, 0, 1, 1, 0, 0, 0, 8'h33, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 1, 0, 0, 0, 8'h33, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 8'h40, 0));
    // both grants high: source 1 wins
    tbl.push_back(mk(1, 8'h50, 1, 8'h60, 0, 0, 1, 1, 0, 0, 0, 8'h40, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 1, 1, 1, 0, 1, 0, 8'h40, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 1, 1, 0, 0, 1, 8'h50, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 8'h60, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 8'h60, 1));

    // Reset held 3 cycles with source 1 offering data.
    reset_n = 1'b0;
    drive(1, 8'h55, 0, 8'h00, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_hold req_1", 16'(bus.req_1), 16'd0);
    chk("rst_hold out_data", 16'(bus.out_data), 16'd0);
    bus.in1_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_rel in1_ready", 16'(bus.in1_ready), 16'd1);
    chk("rst_rel in2_ready", 16'(bus.in2_ready), 16'd1);
    chk("rst_rel req_1", 16'(bus.req_1), 16'd0);
    chk("rst_rel req_2", 16'(bus.req_2), 16'd0);
    chk("rst_rel out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_rel out_src", 16'(bus.out_src), 16'd0);
`ifdef ARB_REQ_QUEUE_STATS_EN
    chk("rst_rel spur_cnt", spur_cnt, 16'd0);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2, tbl[i].g1, tbl[i].g2);
      @(negedge clk);
      chk($sformatf("v%0d in1_ready", i), 16'(bus.in1_ready), 16'(tbl[i].rdy1));
      chk($sformatf("v%0d in2_ready", i), 16'(bus.in2_ready), 16'(tbl[i].rdy2));
      chk($sformatf("v%0d req_1", i), 16'(bus.req_1), 16'(tbl[i].rq1));
      chk($sformatf("v%0d req_2", i), 16'(bus.req_2), 16'(tbl[i].rq2));
      chk($sformatf("v%0d out_valid", i), 16'(bus.out_valid), 16'(tbl[i].ov));
      chk($sformatf("v%0d out_data", i), 16'(bus.out_data), 16'(tbl[i].od));
      chk($sformatf("v%0d out_src", i), 16'(bus.out_src), 16'(tbl[i].os));
    end
    @(posedge clk);
    #1;
    drive(0, 8'h00, 0, 8'h00, 0, 0);
`ifdef ARB_REQ_QUEUE_STATS_EN
    // Spurious cycles in the table: empty grant_2, empty grant_1, grant_2 under grant_1.
    chk("table spur_cnt", spur_cnt, 16'd3);
`endif

    // Spurious grant_2 for 5 cycles on empty FIFOs, from a fresh reset.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.grant_2 = 1'b1;
      @(negedge clk);
      chk($sformatf("spur%0d out_valid", i), 16'(bus.out_valid), 16'd0);
      chk($sformatf("spur%0d req_2", i), 16'(bus.req_2), 16'd0);
    end
    @(posedge clk);
    #1;
    bus.grant_2 = 1'b0;
    @(negedge clk);
    chk("spur_end out_valid", 16'(bus.out_valid), 16'd0);
`ifdef ARB_REQ_QUEUE_STATS_EN
    chk("spur_end spur_cnt", spur_cnt, 16'd5);
`endif

    // Reset mid-drain: queue 3 in source 1, pop one, reset during the next grant.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      drive(1, 8'h70 + 8'(i), 0, 8'h00, 0, 0);
    end
    @(posedge clk);
    #1;
    drive(0, 8'h00, 0, 8'h00, 1, 0);
    @(negedge clk);
    chk("mid req_1 queued", 16'(bus.req_1), 16'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid first out_valid", 16'(bus.out_valid), 16'd1);
    chk("mid first out_data", 16'(bus.out_data), 16'h70);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid in_rst out_valid", 16'(bus.out_valid), 16'd0);
    chk("mid in_rst req_1", 16'(bus.req_1), 16'd0);
    chk("mid in_rst out_data", 16'(bus.out_data), 16'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk($sformatf("mid post%0d out_valid", i), 16'(bus.out_valid), 16'd0);
      chk($sformatf("mid post%0d req_1", i), 16'(bus.req_1), 16'd0);
      chk($sformatf("mid post%0d in1_ready", i), 16'(bus.in1_ready), 16'd1);
    end
    bus.grant_1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
